// File: rtl/vga_pkg.sv
// Shared picture geometry and arbiter grant encoding for the VGA picture path.
package vga_pkg;
  localparam int PIC_W     = 220;
  localparam int PIC_H     = 180;
  localparam int PIC_DEPTH = PIC_W * PIC_H;
  localparam int DATA_W    = 8;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_WR   = 2'd2
  } gnt_e;
endpackage

// File: rtl/pic_ram_arbiter_wr_fifo2.sv
// Two-entry write buffer with occupancy count; push and pop may coincide.
module wr_fifo2 #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  // Caller only pushes when count < 2 and only pops when count > 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/pic_ram_arbiter.sv
// Shares the single-port picture RAM between display fetch (always wins) and
// buffered loader writes that commit only in display gaps.
module pic_ram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = vga_pkg::DATA_W,
  parameter int PIC_DEPTH = vga_pkg::PIC_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_active,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              load_clr,
  output logic              load_done,
  output logic              err_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  import vga_pkg::*;

  localparam int                FW        = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(PIC_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_CNT  = ADDR_W'(PIC_DEPTH - 1);

  logic [FW-1:0]     head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [1:0]        fifo_count;
  logic              push, pop, head_ok, commit;

  gnt_e              gnt_q;
  logic              wr_ok_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [1:0]        rd_pipe_q;
  logic              disp_valid_q;
  logic [DATA_W-1:0] disp_data_q;
  logic [ADDR_W-1:0] commit_cnt_q, commit_cnt_d;
  logic              load_done_q, err_addr_q;

  assign wr_ready               = (fifo_count < 2'd2);
  assign push                   = wr_valid && wr_ready;
  assign pop                    = !disp_active && (fifo_count != 2'd0);
  assign {head_addr, head_data} = head;
  assign head_ok                = (head_addr < DEPTH_A);
  assign commit                 = pop && head_ok;

  wr_fifo2 #(.W(FW)) u_wr_fifo2 (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({wr_addr, wr_data}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q       <= GNT_IDLE;
      wr_ok_q     <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else if (disp_active) begin
      gnt_q      <= GNT_DISP;
      wr_ok_q    <= 1'b0;
      ram_addr_q <= disp_addr;
    end else if (pop) begin
      gnt_q       <= GNT_WR;
      wr_ok_q     <= head_ok;
      ram_addr_q  <= head_addr;
      ram_wdata_q <= head_data;
    end else begin
      gnt_q   <= GNT_IDLE;
      wr_ok_q <= 1'b0;
    end
  end

  // Address out at n+1, RAM data back at n+2, registered to the display at n+3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pipe_q    <= 2'b00;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      rd_pipe_q    <= {rd_pipe_q[0], disp_active};
      disp_valid_q <= rd_pipe_q[1];
      if (rd_pipe_q[1]) disp_data_q <= ram_rdata;
    end
  end

  always_comb begin
    commit_cnt_d = commit_cnt_q;
    if (load_clr)
      commit_cnt_d = '0;
    else if (commit && (commit_cnt_q != DEPTH_A))
      commit_cnt_d = commit_cnt_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_cnt_q <= '0;
      load_done_q  <= 1'b0;
      err_addr_q   <= 1'b0;
    end else begin
      commit_cnt_q <= commit_cnt_d;
      if (load_clr) begin
        load_done_q <= 1'b0;
        err_addr_q  <= 1'b0;
      end else begin
        if (commit && (commit_cnt_q == LAST_CNT)) load_done_q <= 1'b1;
        if (pop && !head_ok) err_addr_q <= 1'b1;
      end
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_we     = (gnt_q == GNT_WR) && wr_ok_q;
  assign ram_wdata  = ram_wdata_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign load_done  = load_done_q;
  assign err_addr   = err_addr_q;
endmodule

// File: tb/tb_pic_ram_arbiter.sv
// Directed bench for pic_ram_arbiter with a behavioural single-port RAM.
module tb_pic_ram_arbiter;
  localparam int DEPTH = 39600;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_active;
  logic [15:0] disp_addr;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        load_clr;
  logic        load_done;
  logic        err_addr;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int          n_cmp;
  int          n_mis;
  int          we_seen;
  int          valid_seen;
  logic [7:0]  mem [0:65535];
  bit          mem_ready;
  logic [23:0] exp_q [$];
  logic [2:0]  act_h;
  logic [15:0] addr_h [3];

  always #5 clk = ~clk;

  pic_ram_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .disp_active (disp_active),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data),
    .disp_valid  (disp_valid),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .load_clr    (load_clr),
    .load_done   (load_done),
    .err_addr    (err_addr),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'(i) ^ 8'hA5;
      mem_ready <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [7:0] pre(input logic [15:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: log accepted writes and display requests, then check RAM port and display output.
  task automatic cyc();
    logic [23:0] e;
    if (wr_valid && wr_ready && (wr_addr < DEPTH)) exp_q.push_back({wr_addr, wr_data});
    act_h     = {act_h[1:0], disp_active};
    addr_h[2] = addr_h[1];
    addr_h[1] = addr_h[0];
    addr_h[0] = disp_addr;
    @(posedge clk);
    #1;
    if (ram_we) begin
      we_seen++;
      chk("we_gap", act_h[0], 0);
      chk("we_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("we_addr", ram_addr, e[23:8]);
        chk("we_data", ram_wdata, e[7:0]);
      end
    end
    if (disp_valid) valid_seen++;
    chk("disp_valid", disp_valid, act_h[2]);
    if (act_h[2]) chk("disp_data", disp_data, pre(addr_h[2]));
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    bit ok;
    ok       = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    for (int t = 0; t < 20 && !ok; t++) begin
      ok = wr_ready;
      cyc();
    end
    if (!ok) chk("push_timeout", ok, 1);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    disp_active = 1'b0;
    disp_addr   = '0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    load_clr    = 1'b0;
    exp_q.delete();
    act_h       = '0;
    addr_h[0]   = '0;
    addr_h[1]   = '0;
    addr_h[2]   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rdy_in_rst", wr_ready, 1);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    bit acc_now;
    n_cmp = 0; n_mis = 0; we_seen = 0; valid_seen = 0;
    do_reset();
    chk("rst_valid", disp_valid, 0);
    chk("rst_data", disp_data, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", err_addr, 0);
    chk("rst_rdy", wr_ready, 1);

    // display only
    we_seen = 0; valid_seen = 0;
    for (int k = 0; k < 10; k++) begin
      disp_active = 1'b1;
      disp_addr   = 16'(k);
      cyc();
    end
    disp_active = 1'b0;
    repeat (5) cyc();
    chk("disp_valid_cnt", valid_seen, 10);
    chk("disp_no_we", we_seen, 0);

    // backpressure
    disp_active = 1'b1; disp_addr = 16'd50;
    wr_valid = 1'b1; wr_addr = 16'd10; wr_data = 8'h11;
    chk("bp_rdy0", wr_ready, 1);
    cyc();
    wr_addr = 16'd11; wr_data = 8'h22;
    chk("bp_rdy1", wr_ready, 1);
    cyc();
    wr_addr = 16'd12; wr_data = 8'h33;
    chk("bp_rdy2", wr_ready, 0);
    cyc();
    wr_valid = 1'b0;
    we_seen = 0;
    repeat (4) cyc();
    chk("bp_hold", we_seen, 0);
    chk("bp_rdy_hold", wr_ready, 0);
    disp_active = 1'b0;
    cyc();
    chk("bp_we0", ram_we, 1);
    chk("bp_addr0", ram_addr, 10);
    chk("bp_rdy_back", wr_ready, 1);
    cyc();
    chk("bp_we1", ram_we, 1);
    chk("bp_addr1", ram_addr, 11);
    cyc();
    chk("bp_we_end", ram_we, 0);
    chk("bp_drain", exp_q.size(), 0);

    // interleave
    we_seen = 0; acc = 0;
    for (int k = 0; k < 24; k++) begin
      disp_active = (k % 2 == 0) && (k < 20);
      disp_addr   = 16'(300 + k);
      wr_valid    = (k < 20);
      wr_addr     = 16'(200 + acc);
      wr_data     = 8'(8'h80 + acc);
      acc_now     = wr_valid && wr_ready;
      cyc();
      if (acc_now) acc++;
    end
    chk("il_drain", exp_q.size(), 0);
    chk("il_count", we_seen, acc);
    chk("il_min", acc >= 10, 1);

    // range check
    wr_valid = 1'b1; wr_addr = 16'd39600; wr_data = 8'h77;
    cyc();
    wr_addr = 16'd0; wr_data = 8'h66;
    chk("rng_err_pre", err_addr, 0);
    cyc();
    wr_valid = 1'b0;
    chk("rng_err", err_addr, 1);
    chk("rng_no_we", ram_we, 0);
    cyc();
    chk("rng_ok_we", ram_we, 1);
    chk("rng_ok_addr", ram_addr, 0);
    chk("rng_ok_data", ram_wdata, 8'h66);
    cyc();
    chk("rng_err_sticky", err_addr, 1);

    // clear while a commit lands: that commit and the earlier one must not count
    wr_valid = 1'b1; wr_addr = 16'd5; wr_data = 8'h5E;
    cyc();
    wr_valid = 1'b0; load_clr = 1'b1;
    cyc();
    load_clr = 1'b0;
    chk("clr_err", err_addr, 0);
    chk("clr_done", load_done, 0);
    chk("clr_we", ram_we, 1);
    cyc();

    // load completion
    for (int i = 0; i < DEPTH; i++) push_wr(16'(i), 8'(i) ^ 8'h3C);
    wr_valid = 1'b0;
    chk("ld_pre", load_done, 0);
    cyc();
    chk("ld_done", load_done, 1);
    chk("ld_last_addr", ram_addr, DEPTH - 1);
    push_wr(16'd100, 8'hC1);
    push_wr(16'd101, 8'hC2);
    wr_valid = 1'b0;
    repeat (3) cyc();
    chk("ld_sat", load_done, 1);
    push_wr(16'd7, 8'h70);
    wr_valid = 1'b0; load_clr = 1'b1;
    cyc();
    load_clr = 1'b0;
    chk("ld_clr", load_done, 0);
    chk("ld_clr_we", ram_we, 1);
    cyc();
    chk("ld_clr_hold", load_done, 0);

    // reset mid-operation
    disp_active = 1'b1;
    for (int k = 0; k < 4; k++) begin
      disp_addr = 16'(40000 + k);
      wr_valid  = (k < 2);
      wr_addr   = 16'(20 + k);
      wr_data   = 8'(8'hD0 + k);
      cyc();
    end
    wr_valid = 1'b0;
    chk("pre_rst_valid", disp_valid, 1);
    chk("pre_rst_rdy", wr_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", disp_valid, 0);
    chk("mid_rst_data", disp_data, 0);
    chk("mid_rst_addr", ram_addr, 0);
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_rdy", wr_ready, 1);
    exp_q.delete();
    act_h = '0;
    disp_active = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    we_seen = 0;
    repeat (5) cyc();
    chk("rst_no_we", we_seen, 0);
    chk("rst_rdy_after", wr_ready, 1);
    push_wr(16'd30, 8'h99);
    wr_valid = 1'b0;
    repeat (2) cyc();
    chk("rst_new_we", we_seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
